// File: rtl/wave_capture.sv
// Producer side of the double-buffered waveform RAM: arms on a positive-going zero
// crossing and writes one full buffer half. Optional forced trigger: WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture #(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int OUT_WIDTH       = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    read_index,
  output logic [ADDR_WIDTH:0]     write_address,
  output logic                    write_enable,
  output logic [OUT_WIDTH-1:0]    write_sample,
  output logic                    active
);

  typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_t;

  generate
    if (OUT_WIDTH > SAMPLE_WIDTH || OUT_WIDTH < 2 || TIMEOUT_SAMPLES < 1) begin : g_bad_cfg
      $error("wave_capture: bad parameter combination");
    end
  endgenerate

  state_t                state;
  logic [ADDR_WIDTH-1:0] counter;
  logic                  prev_neg;
  logic                  wr_half;
  logic                  seen_index;
  logic                  timeout_hit;

  logic                  s_neg;
  logic [OUT_WIDTH-1:0]  s_conv;

  assign s_neg  = new_sample_in[SAMPLE_WIDTH-1];
  // Signed to offset binary: flip the sign bit, keep the top magnitude bits.
  assign s_conv = {~s_neg, new_sample_in[SAMPLE_WIDTH-2 : SAMPLE_WIDTH-OUT_WIDTH]};

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
  logic [TW-1:0] tcount;

  // Held at zero outside ARMED, so every ARMED entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                               tcount <= '0;
    else if (state != S_ARMED)                               tcount <= '0;
    else if (new_sample_ready && tcount != TW'(TIMEOUT_SAMPLES)) tcount <= tcount + 1'b1;
  end

  assign timeout_hit = (state == S_ARMED) && (tcount == TW'(TIMEOUT_SAMPLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_ARMED;
      counter       <= '0;
      prev_neg      <= 1'b0;
      wr_half       <= 1'b0;
      seen_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      active        <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      if (new_sample_ready) prev_neg <= s_neg;
      case (state)
        S_ARMED: begin
          // Trigger strobe itself is not written.
          if (new_sample_ready && ((prev_neg && !s_neg) || timeout_hit)) begin
            state      <= S_ACTIVE;
            active     <= 1'b1;
            counter    <= '0;
            wr_half    <= ~read_index;
            seen_index <= read_index;
          end
        end
        S_ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {wr_half, counter};
            write_sample  <= s_conv;
            counter       <= counter + 1'b1;
            if (&counter) begin
              state  <= S_WAIT;
              active <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          // Re-arm only once the flip controller has swapped halves.
          if (read_index != seen_index) state <= S_ARMED;
        end
        default: begin
          state  <= S_ARMED;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
